// File: rtl/inst_fetch_unit.sv
// Instruction fetch: requests cache lines, splits each 64-bit beat into two instructions,
// buffers them in a FIFO and hands them to the decoder. Optional counters under FETCH_PERF_EN.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module inst_fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS_PER_LINE = 8,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc,
  input  logic                      inst_ready,
  output logic                      done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               lines_fetched
`endif
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BEAT_W     = $clog2(BEATS_PER_LINE);
  localparam int LINE_BYTES = BEATS_PER_LINE * 8;

  typedef enum logic [2:0] {S_INIT, S_REQ, S_WAIT, S_RECV, S_HALT} state_t;

  state_t              state_q;
  logic [63:0]         fetch_pc_q;
  logic [63:0]         skip_pc_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic                halt_q;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [95:0]         mem_q [FIFO_DEPTH];

  logic [63:0]         line_addr, lo_addr, hi_addr;
  logic [31:0]         lo_word, hi_word;
  logic                beat_active, last_beat;
  logic                lo_live, lo_zero, hi_live, hi_zero, zero_hit;
  logic                push_lo, push_hi, pop, space_ok;
  logic [1:0]          n_push;
  logic [PTR_W-1:0]    wr_ptr_p1;
  logic                unused_ok;

  assign unused_ok = ^bus_resptag;

  assign line_addr = fetch_pc_q & ~64'(LINE_BYTES - 1);
  assign lo_addr   = line_addr + (64'(beat_cnt_q) << 3);
  assign hi_addr   = lo_addr + 64'd4;
  assign lo_word   = bus_resp[31:0];
  assign hi_word   = bus_resp[63:32];

  assign beat_active = bus_respcyc && (state_q == S_WAIT || state_q == S_RECV);
  assign last_beat   = (beat_cnt_q == BEAT_W'(BEATS_PER_LINE - 1));

  // A zero word ends the program: it and every later word of the line are discarded.
  assign lo_live  = !halt_q && (lo_addr >= skip_pc_q);
  assign lo_zero  = lo_live && (lo_word == 32'h0);
  assign hi_live  = !halt_q && !lo_zero && (hi_addr >= skip_pc_q);
  assign hi_zero  = hi_live && (hi_word == 32'h0);
  assign zero_hit = beat_active && (lo_zero || hi_zero);
  assign push_lo  = beat_active && lo_live && !lo_zero;
  assign push_hi  = beat_active && hi_live && !hi_zero;
  assign n_push   = {1'b0, push_lo} + {1'b0, push_hi};

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign space_ok   = (count_q <= CNT_W'(FIFO_DEPTH - 2 * BEATS_PER_LINE));

  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
  assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  assign count_d   = count_q + CNT_W'(n_push) - CNT_W'(pop);

  assign bus_reqcyc  = (state_q == S_REQ) && space_ok;
  assign bus_req     = line_addr;
  assign bus_reqtag  = BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'h0});
  assign bus_respack = beat_active;
  assign inst        = inst_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign inst_pc     = inst_valid ? mem_q[rd_ptr_q][95:32] : 64'h0;
  assign done        = (state_q == S_HALT) && (count_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      fetch_pc_q <= 64'h0;
      skip_pc_q  <= 64'h0;
      beat_cnt_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          fetch_pc_q <= entry;
          skip_pc_q  <= entry;
          state_q    <= S_REQ;
        end
        S_REQ: begin
          if (bus_reqcyc && bus_reqack) state_q <= S_WAIT;
        end
        S_WAIT, S_RECV: begin
          if (beat_active) begin
            if (zero_hit) halt_q <= 1'b1;
            if (last_beat) begin
              beat_cnt_q <= '0;
              fetch_pc_q <= line_addr + 64'(LINE_BYTES);
              state_q    <= (halt_q || zero_hit) ? S_HALT : S_REQ;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
              state_q    <= S_RECV;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The low word always takes the first free slot when both words are kept.
  always_ff @(posedge clk) begin
    if (push_lo) mem_q[wr_ptr_q] <= {lo_addr, lo_word};
    if (push_hi) mem_q[push_lo ? wr_ptr_p1 : wr_ptr_q] <= {hi_addr, hi_word};
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q, lines_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'h0;
      lines_q <= 32'h0;
    end else begin
      if (!inst_valid && !done && state_q != S_INIT && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (bus_reqcyc && bus_reqack) lines_q <= lines_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign lines_fetched = lines_q;
`endif

endmodule
